// File: rtl/dc_axi_pkg.sv
// -----------------------------------------------------------------------------
// dc_axi_pkg
// Shared definitions for the D-cache AXI line-fill read master:
//   - rd_state_t      : FSM state encoding (IDLE / ARQ / RDAT / DONE)
//   - AXI_ARLEN       : burst length field (4 beats -> 3)
//   - AXI_ARSIZE      : beat size field (4 bytes -> 2)
//   - AXI_BURST_INCR  : incrementing burst type
//   - LINE_BEATS      : beats per cache line
// -----------------------------------------------------------------------------
package dc_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARQ  = 2'd1,
        ST_RDAT = 2'd2,
        ST_DONE = 2'd3
    } rd_state_t;

    localparam logic [7:0] AXI_ARLEN      = 8'd3;
    localparam logic [2:0] AXI_ARSIZE     = 3'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         LINE_BEATS     = 4;

endpackage

// File: rtl/dc_rbeat_asm.sv
// -----------------------------------------------------------------------------
// dc_rbeat_asm
// Assembles four 32-bit AXI read beats into one 128-bit cache line.
// Beat k lands in line bits [32k+31:32k]; beat 0 is the least significant word.
// The line is cleared when a new fill begins so that words never received
// (e.g. a timed-out burst) read as zero, and otherwise holds its value.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   i_clr        in   new fill starting: zero the line and the beat counter
//   i_beat_vld   in   R-channel handshake this cycle
//   i_beat_data  in   32-bit read data of the accepted beat
//   o_line       out  assembled 128-bit line
//   o_beat_last  out  the next accepted beat is the final (fourth) beat
// -----------------------------------------------------------------------------
module dc_rbeat_asm (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_beat_vld,
    input  logic [31:0]  i_beat_data,
    output logic [127:0] o_line,
    output logic         o_beat_last
);

    logic [1:0]   r_beat;
    logic [127:0] r_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= 2'd0;
            r_line <= 128'd0;
        end else if (i_clr) begin
            r_beat <= 2'd0;
            r_line <= 128'd0;
        end else if (i_beat_vld) begin
            case (r_beat)
                2'd0:    r_line[31:0]   <= i_beat_data;
                2'd1:    r_line[63:32]  <= i_beat_data;
                2'd2:    r_line[95:64]  <= i_beat_data;
                default: r_line[127:96] <= i_beat_data;
            endcase
            // wraps back to 0 after the fourth beat
            r_beat <= r_beat + 2'd1;
        end
    end

    assign o_line      = r_line;
    assign o_beat_last = (r_beat == 2'd3);

endmodule

// File: rtl/dc_axi_rd_master.sv
// -----------------------------------------------------------------------------
// dc_axi_rd_master
// D-cache line-fill AXI read master. A one-cycle request from the LSU launches
// a single 4-beat x 32-bit INCR burst on a 16-byte aligned address; the beats
// are assembled into a 128-bit line that is presented with a one-cycle strobe.
//
// Optional feature (compile-time macro DCRD_WATCHDOG_EN):
//   A TMO_W-bit watchdog counts stalled cycles in ARQ/RDAT. When it reaches
//   all-ones the fill is forced to DONE with the words received so far
//   (missing words read as zero) and tmo_err is set. Without the macro the
//   FSM waits indefinitely and tmo_err reads 0. TMO_W must be >= 2.
//
// Ports:
//   clk, rst          clock / synchronous active-high reset
//   rst_pipe          pipeline flush: suppresses the result of an in-flight fill
//   dcr_start_rq      line-fill request pulse
//   dcr_rin_addr      fill address (sampled with dcr_start_rq)
//   rqfull_1          busy, requests are not accepted
//   rdat_m_data       assembled 128-bit line
//   rdat_m_valid      line valid strobe (1 cycle)
//   finish_mrd        fill done strobe (1 cycle)
//   araddr/arlen/arsize/arburst/arvalid/arready   AXI read-address channel
//   rdata/rresp/rlast/rvalid/rready               AXI read-data channel
//   err_sts           sticky {tmo_err, proto_err, ovr_err}, cleared only by rst
// -----------------------------------------------------------------------------
module dc_axi_rd_master
    import dc_axi_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int TMO_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_pipe,
    input  logic              dcr_start_rq,
    input  logic [AWIDTH-1:0] dcr_rin_addr,
    output logic              rqfull_1,
    output logic [127:0]      rdat_m_data,
    output logic              rdat_m_valid,
    output logic              finish_mrd,
    output logic [AWIDTH-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [2:0]        err_sts
);

    rd_state_t         r_state;
    rd_state_t         w_state_nxt;

    logic [AWIDTH-1:0] r_araddr;
    logic              r_flush;
    logic              r_ovr_err;
    logic              r_proto_err;

    logic              w_fill_start;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_beat_last;
    logic              w_done;
    logic              w_tmo;
    logic              w_tmo_err;
    logic [127:0]      w_line;
    logic [3:0]        w_addr_unused;

    // line offset bits are discarded by the alignment
    assign w_addr_unused = dcr_rin_addr[3:0];

    // A flush coinciding with the request cancels the request outright.
    assign w_fill_start = (r_state == ST_IDLE) && dcr_start_rq && !rst_pipe;
    assign w_ar_hs      = arvalid && arready;
    assign w_r_hs       = rvalid && rready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fill_start) begin
                    w_state_nxt = ST_ARQ;
                end
            end
            ST_ARQ: begin
                if (w_ar_hs) begin
                    w_state_nxt = ST_RDAT;
                end else if (w_tmo) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_RDAT: begin
                // fourth beat ends the burst whatever rlast says
                if (w_r_hs && w_beat_last) begin
                    w_state_nxt = ST_DONE;
                end else if (w_tmo) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- FSM: output decode ----------------
    always_comb begin
        arvalid  = 1'b0;
        rready   = 1'b0;
        rqfull_1 = 1'b1;
        w_done   = 1'b0;
        case (r_state)
            ST_IDLE: rqfull_1 = 1'b0;
            ST_ARQ:  arvalid  = 1'b1;
            ST_RDAT: rready   = 1'b1;
            ST_DONE: w_done   = 1'b1;
            default: rqfull_1 = 1'b0;
        endcase
    end

    // A flushed fill still drains on AXI but reports nothing to the LSU.
    assign rdat_m_valid = w_done && !r_flush;
    assign finish_mrd   = w_done && !r_flush;

    // ---------------- address latch and flush tracking ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_araddr <= '0;
            r_flush  <= 1'b0;
        end else begin
            if (w_fill_start) begin
                r_araddr <= {dcr_rin_addr[AWIDTH-1:4], 4'h0};
            end
            if (w_fill_start) begin
                r_flush <= 1'b0;
            end else if (rst_pipe && ((r_state == ST_ARQ) || (r_state == ST_RDAT))) begin
                r_flush <= 1'b1;
            end
        end
    end

    assign araddr  = r_araddr;
    assign arlen   = AXI_ARLEN;
    assign arsize  = AXI_ARSIZE;
    assign arburst = AXI_BURST_INCR;

    // ---------------- sticky error flags ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr_err   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (dcr_start_rq && (r_state != ST_IDLE)) begin
                r_ovr_err <= 1'b1;
            end
            // rlast must appear on the fourth beat and nowhere else
            if (w_r_hs && ((rresp != 2'b00) || (rlast != w_beat_last))) begin
                r_proto_err <= 1'b1;
            end
        end
    end

`ifdef DCRD_WATCHDOG_EN
    // Trip one count early so DONE is entered on the edge the counter
    // reaches all-ones.
    localparam logic [TMO_W-1:0] WDOG_TRIP = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [TMO_W-1:0] WDOG_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

    logic [TMO_W-1:0] r_wdog;
    logic             r_tmo_err;
    logic             w_wdog_act;

    assign w_wdog_act = (r_state == ST_ARQ) || (r_state == ST_RDAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog    <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            if (!w_wdog_act || w_ar_hs || w_r_hs) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + WDOG_ONE;
            end
            if (w_tmo) begin
                r_tmo_err <= 1'b1;
            end
        end
    end

    assign w_tmo     = w_wdog_act && !w_ar_hs && !w_r_hs && (r_wdog == WDOG_TRIP);
    assign w_tmo_err = r_tmo_err;
`else
    localparam int unused_tmo_w = TMO_W;

    assign w_tmo     = 1'b0;
    assign w_tmo_err = 1'b0;
`endif

    assign err_sts = {w_tmo_err, r_proto_err, r_ovr_err};

    // ---------------- beat assembly ----------------
    dc_rbeat_asm u_asm (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_fill_start),
        .i_beat_vld  (w_r_hs),
        .i_beat_data (rdata),
        .o_line      (w_line),
        .o_beat_last (w_beat_last)
    );

    assign rdat_m_data = w_line;

endmodule

// File: tb/tb_dc_axi_rd_master.sv
// Self-checking bench for dc_axi_rd_master. Expected values come from a
// transaction-level model: each fill's line is the concatenation of the beats
// the bench sent, and the error bits are derived from what the bench injected.
module tb_dc_axi_rd_master;

    localparam int AW = 32;

    logic          clk;
    logic          rst;
    logic          rst_pipe;
    logic          dcr_start_rq;
    logic [AW-1:0] dcr_rin_addr;
    logic          rqfull_1;
    logic [127:0]  rdat_m_data;
    logic          rdat_m_valid;
    logic          finish_mrd;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;
    logic [2:0]    err_sts;

    dc_axi_rd_master #(.AWIDTH(AW), .TMO_W(4)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .rst_pipe     (rst_pipe),
        .dcr_start_rq (dcr_start_rq),
        .dcr_rin_addr (dcr_rin_addr),
        .rqfull_1     (rqfull_1),
        .rdat_m_data  (rdat_m_data),
        .rdat_m_valid (rdat_m_valid),
        .finish_mrd   (finish_mrd),
        .araddr       (araddr),
        .arlen        (arlen),
        .arsize       (arsize),
        .arburst      (arburst),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready),
        .err_sts      (err_sts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // observed-event counters kept by the monitor
    int n_ar_hs = 0;
    int n_pulse = 0;

    // model state
    logic [AW-1:0] exp_araddr = '0;
    bit            m_ovr, m_proto, m_tmo;
    logic [31:0]   fix_data [4];
    bit            use_fix;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // passive monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (arvalid) begin
                check_val("araddr_hold", araddr, exp_araddr);
            end
            if (arvalid && arready) begin
                n_ar_hs++;
                check_val("ar_fields", {arlen, arsize, arburst}, {8'd3, 3'd2, 2'b01});
            end
            if (rdat_m_valid) begin
                n_pulse++;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        rst_pipe = 1'b0; dcr_start_rq = 1'b0; dcr_rin_addr = '0;
        arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        m_ovr = 0; m_proto = 0; m_tmo = 0;
    endtask

    task automatic wait_rhs();
        bit ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (rready) ok = 1;
            tick();
        end
        if (!ok) check_val("r_timeout", 0, 1);
    endtask

    // One complete fill. Indices <0 disable the corresponding injection.
    task automatic run_fill(input logic [AW-1:0] addr, input int ar_wait, input int gap,
                            input int rlast_extra, input int bad_resp,
                            input int flush_beat, input int ovr_beat);
        logic [127:0] exp_line;
        int  ar0, pu0;
        bit  fl, ok;
        ar0 = n_ar_hs; pu0 = n_pulse;
        exp_line = '0; fl = 0; ok = 0;
        exp_araddr = {addr[AW-1:4], 4'h0};
        dcr_start_rq = 1'b1; dcr_rin_addr = addr; arready = (ar_wait == 0);
        tick();
        dcr_start_rq = 1'b0; dcr_rin_addr = $urandom;
        check_val("arvalid_first", arvalid, 1);
        check_val("busy", rqfull_1, 1);
        check_val("araddr_align", araddr, exp_araddr);
        arready = 1'b0;
        for (int i = 0; i < ar_wait; i++) tick();
        arready = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (arvalid) ok = 1;
            tick();
        end
        if (!ok) check_val("ar_timeout", 0, 1);
        arready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) tick();
            rvalid = 1'b1;
            rdata  = use_fix ? fix_data[k] : $urandom;
            rlast  = (k == 3) || (k == rlast_extra);
            rresp  = (k == bad_resp) ? 2'd2 : 2'd0;
            if (k == rlast_extra || k == bad_resp) m_proto = 1;
            if (k == flush_beat) begin rst_pipe = 1'b1; fl = 1; end
            if (k == ovr_beat) begin dcr_start_rq = 1'b1; dcr_rin_addr = $urandom; m_ovr = 1; end
            exp_line[32*k +: 32] = rdata;
            wait_rhs();
            rst_pipe = 1'b0; dcr_start_rq = 1'b0;
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
        end
        check_val("valid_done", rdat_m_valid, !fl);
        check_val("finish_done", finish_mrd, !fl);
        check_val("busy_done", rqfull_1, 1);
        check_val("err_sts", err_sts, {m_tmo, m_proto, m_ovr});
        if (!fl) check_val("line", rdat_m_data, exp_line);
        tick();
        check_val("valid_after", rdat_m_valid, 0);
        check_val("idle_after", rqfull_1, 0);
        if (!fl) check_val("line_hold", rdat_m_data, exp_line);
        check_val("ar_count", n_ar_hs - ar0, 1);
        check_val("pulse_count", n_pulse - pu0, fl ? 0 : 1);
    endtask

    initial begin
        use_fix = 0;
        do_reset();
        check_val("rst_arvalid", arvalid, 0);
        check_val("rst_rready", rready, 0);
        check_val("rst_busy", rqfull_1, 0);
        check_val("rst_valid", {rdat_m_valid, finish_mrd}, 0);
        check_val("rst_data", rdat_m_data, 0);
        check_val("rst_araddr", araddr, 0);
        check_val("rst_err", err_sts, 0);

        // basic fill with known data
        use_fix = 1;
        fix_data[0] = 32'h11; fix_data[1] = 32'h22; fix_data[2] = 32'h33; fix_data[3] = 32'h44;
        run_fill(32'h0000_1234, 0, 0, -1, -1, -1, -1);
        check_val("basic_line", rdat_m_data, 128'h00000044_00000033_00000022_00000011);
        check_val("basic_araddr", araddr, 32'h0000_1230);
        use_fix = 0;

        // AR backpressure and R gaps
        run_fill(32'hABCD_EF07, 5, 2, -1, -1, -1, -1);

        // overrun during RDAT is dropped
        begin
            int ar0;
            run_fill(32'h0000_5000, 1, 0, -1, -1, -1, 1);
            ar0 = n_ar_hs;
            tick(); tick();
            check_val("ovr_dropped", n_ar_hs - ar0, 0);
            check_val("ovr_idle", rqfull_1, 0);
            check_val("ovr_sticky", err_sts[0], 1);
        end

        do_reset();
        check_val("err_cleared", err_sts, 0);

        // flush after beat 1, then protocol errors
        run_fill(32'h0000_6010, 0, 1, -1, -1, 2, -1);
        run_fill(32'h0000_7020, 0, 0, 1, 2, -1, -1);
        check_val("proto_sticky", err_sts[1], 1);

        // flush with request in IDLE drops it; flush alone in IDLE is harmless
        do_reset();
        rst_pipe = 1'b1; dcr_start_rq = 1'b1; dcr_rin_addr = 32'h8000;
        tick();
        rst_pipe = 1'b0; dcr_start_rq = 1'b0;
        check_val("flush_drop_busy", rqfull_1, 0);
        check_val("flush_drop_ar", arvalid, 0);
        rst_pipe = 1'b1; tick(); rst_pipe = 1'b0;
        run_fill(32'h0000_9000, 0, 0, -1, -1, -1, -1);

        // randomized fills
        for (int i = 0; i < 24; i++) begin
            int rl, br, fb, ob;
            if (i % 8 == 0) do_reset();
            rl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            br = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            fb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            ob = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_fill($urandom, $urandom_range(0, 3), $urandom_range(0, 2), rl, br, fb, ob);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                rst_pipe = $urandom_range(0, 1);
                tick();
                rst_pipe = 1'b0;
            end
        end

        // stalled burst: two beats then silence
        do_reset();
        begin
            logic [31:0] d0, d1;
            int n;
            d0 = $urandom; d1 = $urandom;
            exp_araddr = 32'h0000_4000;
            dcr_start_rq = 1'b1; dcr_rin_addr = 32'h0000_400C; tick();
            dcr_start_rq = 1'b0; arready = 1'b1; tick();
            arready = 1'b0;
            check_val("stall_rdat", rready, 1);
            rvalid = 1'b1; rdata = d0; tick();
            rdata = d1; tick();
            rvalid = 1'b0;
`ifdef DCRD_WATCHDOG_EN
            n = 0;
            while (!rdat_m_valid && n < 100) begin tick(); n++; end
            check_val("wdog_cycles", n, 15);
            check_val("wdog_finish", finish_mrd, 1);
            check_val("wdog_line", rdat_m_data, {64'h0, d1, d0});
            check_val("wdog_err", err_sts, 3'b100);
            tick();
            check_val("wdog_idle", rqfull_1, 0);
            // start another burst to be killed by reset
            dcr_start_rq = 1'b1; dcr_rin_addr = 32'h0000_4000; tick();
            dcr_start_rq = 1'b0; arready = 1'b1; tick();
            arready = 1'b0;
            rvalid = 1'b1; rdata = d0; tick();
`else
            n = n_pulse;
            for (int t = 0; t < 40; t++) tick();
            check_val("nowdog_wait", {rqfull_1, rready}, 2'b11);
            check_val("nowdog_nopulse", n_pulse - n, 0);
            check_val("nowdog_err", err_sts, 0);
`endif
            // reset mid-burst wins over concurrent inputs
            rst = 1'b1; rvalid = 1'b1; dcr_start_rq = 1'b1; tick();
            rst = 1'b0; rvalid = 1'b0; dcr_start_rq = 1'b0;
            check_val("midrst_err", err_sts, 0);
            check_val("midrst_ctl", {rqfull_1, arvalid, rready, rdat_m_valid, finish_mrd}, 0);
            check_val("midrst_data", rdat_m_data, 0);
            check_val("midrst_addr", araddr, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=0 want=1");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/dc_axi_rd_master.md
DC_AXI_RD_MASTER -- requirements
Module: dc_axi_rd_master

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, meaning AXI/request address width.
REQ-002 SHALL have parameter TMO_W, default 10, meaning watchdog counter width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rst_pipe, input, 1 bit: pipeline flush.
REQ-006 SHALL have port dcr_start_rq, input, 1 bit: line-fill request pulse from the LSU.
REQ-007 SHALL have port dcr_rin_addr, input, AWIDTH bits: fill address, sampled with dcr_start_rq.
REQ-008 SHALL have port rqfull_1, output, 1 bit: block busy, no new request accepted.
REQ-009 SHALL have ports rdat_m_data (output, 128 bits), rdat_m_valid (output, 1 bit) and finish_mrd (output, 1 bit): the assembled line, its valid strobe and the fill-done strobe.
REQ-010 SHALL have AXI AR ports: araddr (output, AWIDTH), arlen (output, 8), arsize (output, 3), arburst (output, 2), arvalid (output, 1) and arready (input, 1).
REQ-011 SHALL have AXI R ports: rdata (input, 32), rresp (input, 2), rlast (input, 1), rvalid (input, 1) and rready (output, 1).
REQ-012 SHALL have port err_sts, output, 3 bits: sticky status {tmo_err, proto_err, ovr_err}.

Function
REQ-013 SHALL implement FSM states IDLE, ARQ, RDAT and DONE.
REQ-014 IDLE->ARQ SHALL occur on dcr_start_rq; araddr is latched as {dcr_rin_addr[AWIDTH-1:4], 4'h0}.
REQ-015 arvalid SHALL be high exactly in ARQ, first asserted the cycle after dcr_start_rq; araddr SHALL be held stable while arvalid&~arready.
REQ-016 ARQ->RDAT SHALL occur on arvalid&arready.
REQ-017 arlen, arsize and arburst SHALL be constant at 3, 2 and INCR (4 beats of 32 bits).
REQ-018 rready SHALL be high exactly in RDAT.
REQ-019 A 2-bit beat counter SHALL place an accepted beat k in rdat_m_data[32k+31:32k] (beat 0 = LSW).
REQ-020 RDAT->DONE SHALL occur on acceptance of beat 3, regardless of rlast.
REQ-021 In DONE, rdat_m_valid and finish_mrd SHALL pulse for exactly one cycle, one cycle after beat 3 is accepted; DONE->IDLE follows unconditionally.
REQ-022 rdat_m_data SHALL hold its value until the next fill begins.
REQ-023 rqfull_1 SHALL be high in every state except IDLE.
REQ-024 dcr_start_rq while not IDLE SHALL be dropped and SHALL set ovr_err.
REQ-025 rlast not coinciding with beat 3, or rresp!=0 on any beat, SHALL set proto_err; the burst continues.
REQ-026 rst_pipe in ARQ or RDAT SHALL NOT abort the AXI transaction: the burst drains normally, then rdat_m_valid and finish_mrd are suppressed for that fill.
REQ-027 rst_pipe in IDLE SHALL have no effect; rst_pipe coinciding with dcr_start_rq SHALL drop the request.

Reset
REQ-028 On rst: state=IDLE; arvalid, rready, rdat_m_valid, finish_mrd and rqfull_1 = 0; rdat_m_data, araddr and beat counter = 0; err_sts = 0; watchdog = 0.
REQ-029 rst SHALL take priority over all other inputs, including mid-burst.
REQ-030 err_sts bits SHALL clear only on rst.

Configuration
REQ-031 Macro DCRD_WATCHDOG_EN SHALL control the watchdog feature.
REQ-032 With DCRD_WATCHDOG_EN defined, a TMO_W-bit counter SHALL count cycles in ARQ/RDAT, clear on each AR or R handshake, and on reaching all-ones force DONE: partial line with unreceived words = 0, tmo_err set, strobes pulse normally.
REQ-033 Without DCRD_WATCHDOG_EN, no counter SHALL exist, tmo_err SHALL read 0 and the FSM SHALL wait indefinitely.

Structure
REQ-034 State encodings and the ARLEN/ARSIZE/ARBURST constants SHALL reside in shared package dc_axi_pkg.
REQ-035 Beat placement and the counter SHALL form one sub-module, dc_rbeat_asm.

Verification
REQ-036 Start at cycle 0, addr 0x0000_1234, arready=1, beats 0x11,0x22,0x33,0x44 back-to-back with rlast on beat 3 -> araddr=0x0000_1230, arvalid at cycle 1, rdat_m_data=0x00000044_00000033_00000022_00000011 with a single-cycle strobe, err_sts=0.
REQ-037 arready held low 5 cycles, rvalid gaps of 2 cycles -> araddr stable throughout, exactly one rdat_m_valid pulse.
REQ-038 Second dcr_start_rq during RDAT -> ignored, ovr_err=1, exactly one AR handshake.
REQ-039 rst_pipe in RDAT after beat 1 -> 4 beats accepted, no rdat_m_valid/finish_mrd, back to IDLE.
REQ-040 rlast on beat 1, rresp=2 on beat 2 -> proto_err=1, fill completes after 4 beats.
REQ-041 DCRD_WATCHDOG_EN, TMO_W=4, only 2 beats then silence -> DONE after 15 idle cycles, upper 64 bits 0, tmo_err=1; rst mid-burst clears all.
